bpred_update_queue: RTL and testbench

- Collects branch-resolution updates from two resolve ports (A = older, B = younger in program order) into an in-order FIFO.
- Drains the FIFO one entry per cycle into the single-write-port update interface of the gshare direction predictor: wr_en, orig_pc, is_taken.
- Sits between the branch-resolution stage and the predictor.
- Preserves program order of history updates and gives back-pressure when full.

---
 rtl/bpred_update_queue_if.sv | 31 +++
 rtl/bpred_update_queue.sv | 83 ++++++++
 tb/tb_bpred_update_queue.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/bpred_update_queue_if.sv
// Handshake bundle between branch resolution, the update queue and the gshare predictor.
// master drives the resolve ports and flush/hold; slave is the queue itself.
interface bpred_update_queue_if #(
    parameter int PC_BITS = 32,
    parameter int DEPTH   = 4
);
    logic                       valid_a;
    logic [PC_BITS-1:0]         pc_a;
    logic                       taken_a;
    logic                       ready_a;
    logic                       valid_b;
    logic [PC_BITS-1:0]         pc_b;
    logic                       taken_b;
    logic                       ready_b;
    logic                       flush;
    logic                       hold;
    logic                       upd_wr_en;
    logic [PC_BITS-1:0]         upd_pc;
    logic                       upd_taken;
    logic [$clog2(DEPTH):0]     occupancy;

    modport master (
        output valid_a, pc_a, taken_a, valid_b, pc_b, taken_b, flush, hold,
        input  ready_a, ready_b, upd_wr_en, upd_pc, upd_taken, occupancy
    );

    modport slave (
        input  valid_a, pc_a, taken_a, valid_b, pc_b, taken_b, flush, hold,
        output ready_a, ready_b, upd_wr_en, upd_pc, upd_taken, occupancy
    );
endinterface

// File: rtl/bpred_update_queue.sv
// In-order queue of branch-resolution updates (two pushes per cycle, A older than B),
// drained one entry per cycle into the single write port of the gshare predictor.
module bpred_update_queue #(
    parameter int PC_BITS = 32,
    parameter int DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    bpred_update_queue_if.slave     bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [PC_BITS-1:0] pc;
        logic               taken;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic [PW-1:0]   slot_b;
    logic            acc_a, acc_b, drain;

    // Readiness looks only at the registered count; a same-cycle drain gives no credit.
    assign bus.ready_a = ~bus.flush & (count_q <= CW'(DEPTH - 1));
    assign bus.ready_b = ~bus.flush & (count_q <= CW'(DEPTH - 2));

    assign acc_a  = bus.valid_a & bus.ready_a;
    assign acc_b  = bus.valid_b & bus.ready_b & ~(bus.valid_a & ~bus.ready_a);
    assign slot_b = wr_ptr_q + PW'(acc_a);
    assign drain  = (count_q != '0) & ~bus.hold & ~bus.flush;

    assign bus.upd_wr_en = drain;
    assign bus.upd_pc    = mem_q[rd_ptr_q].pc;
    assign bus.upd_taken = mem_q[rd_ptr_q].taken;
    assign bus.occupancy = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PW'(drain);
            wr_ptr_d = wr_ptr_q + PW'(acc_a) + PW'(acc_b);
            count_d  = count_q + CW'(acc_a) + CW'(acc_b) - CW'(drain);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; slots are only read while count marks them valid.
    always_ff @(posedge clk) begin
        if (acc_a) begin
            mem_q[wr_ptr_q] <= '{pc: bus.pc_a, taken: bus.taken_a};
        end
        if (acc_b) begin
            mem_q[slot_b] <= '{pc: bus.pc_b, taken: bus.taken_b};
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (int'(count_q) + int'(acc_a) + int'(acc_b) <= DEPTH));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(drain && (count_q == '0)));
    a_b_follows_a: assert property (@(posedge clk) disable iff (rst)
        !(bus.valid_a && !bus.ready_a && acc_b));
endmodule

// File: tb/tb_bpred_update_queue.sv
// Directed bench for bpred_update_queue with DEPTH=4: latency, ordering, back-pressure,
// flush, wrap-around and reset behaviour against hand-computed values.
module tb_bpred_update_queue;
    localparam int PC_BITS = 32;
    localparam int DEPTH   = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    bpred_update_queue_if #(.PC_BITS(PC_BITS), .DEPTH(DEPTH)) bus ();

    bpred_update_queue #(.PC_BITS(PC_BITS), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle inputs/outputs away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.valid_a = 1'b0;
        bus.pc_a    = '0;
        bus.taken_a = 1'b0;
        bus.valid_b = 1'b0;
        bus.pc_b    = '0;
        bus.taken_b = 1'b0;
        bus.flush   = 1'b0;
        bus.hold    = 1'b0;
    endtask

    task automatic push_a(input logic [31:0] pc, input logic tk);
        bus.valid_a = 1'b1;
        bus.pc_a    = pc;
        bus.taken_a = tk;
        tick();
        bus.valid_a = 1'b0;
    endtask

    logic [31:0] exp_pc [4];

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_occ",   64'(bus.occupancy), 64'd0);
        chk("rst_wr_en", 64'(bus.upd_wr_en), 64'd0);
        chk("rst_rdy_a", 64'(bus.ready_a),   64'd1);
        chk("rst_rdy_b", 64'(bus.ready_b),   64'd1);

        // Single push, one-cycle latency
        push_a(32'h100, 1'b1);
        chk("lat_wr_en", 64'(bus.upd_wr_en), 64'd1);
        chk("lat_pc",    64'(bus.upd_pc),    64'h100);
        chk("lat_taken", 64'(bus.upd_taken), 64'd1);
        chk("lat_occ",   64'(bus.occupancy), 64'd1);
        tick();
        chk("lat_occ2",  64'(bus.occupancy), 64'd0);
        chk("lat_wr2",   64'(bus.upd_wr_en), 64'd0);

        // Dual push ordering
        bus.valid_a = 1'b1; bus.pc_a = 32'h200; bus.taken_a = 1'b1;
        bus.valid_b = 1'b1; bus.pc_b = 32'h204; bus.taken_b = 1'b0;
        tick();
        idle_inputs();
        chk("dual_occ",    64'(bus.occupancy), 64'd2);
        chk("dual_pc0",    64'(bus.upd_pc),    64'h200);
        chk("dual_tk0",    64'(bus.upd_taken), 64'd1);
        chk("dual_wr0",    64'(bus.upd_wr_en), 64'd1);
        tick();
        chk("dual_pc1",    64'(bus.upd_pc),    64'h204);
        chk("dual_tk1",    64'(bus.upd_taken), 64'd0);
        chk("dual_wr1",    64'(bus.upd_wr_en), 64'd1);
        tick();
        chk("dual_occ_end", 64'(bus.occupancy), 64'd0);

        // Fill under hold, back-pressure, then release
        bus.hold = 1'b1;
        exp_pc[0] = 32'h10; exp_pc[1] = 32'h14; exp_pc[2] = 32'h18; exp_pc[3] = 32'h1C;
        for (int i = 0; i < 4; i++) begin
            push_a(exp_pc[i], i[0]);
            if (i == 2) begin
                chk("hold_c3_rdy_a", 64'(bus.ready_a), 64'd1);
                chk("hold_c3_rdy_b", 64'(bus.ready_b), 64'd0);
            end
        end
        chk("full_occ",   64'(bus.occupancy), 64'd4);
        chk("full_rdy_a", 64'(bus.ready_a),   64'd0);
        chk("full_rdy_b", 64'(bus.ready_b),   64'd0);
        chk("full_wr_en", 64'(bus.upd_wr_en), 64'd0);
        push_a(32'h99, 1'b1);
        chk("full_refuse_occ", 64'(bus.occupancy), 64'd4);
        bus.hold = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rel_wr_en", 64'(bus.upd_wr_en), 64'd1);
            chk("rel_pc",    64'(bus.upd_pc),    64'(exp_pc[i]));
            chk("rel_taken", 64'(bus.upd_taken), 64'(i % 2));
            tick();
        end
        chk("rel_occ_end", 64'(bus.occupancy), 64'd0);
        chk("rel_wr_end",  64'(bus.upd_wr_en), 64'd0);

        // count=3: A accepted, B refused, head drains, count stays 3
        bus.hold = 1'b1;
        push_a(32'h40, 1'b0);
        push_a(32'h44, 1'b1);
        push_a(32'h48, 1'b0);
        bus.hold = 1'b0;
        bus.valid_a = 1'b1; bus.pc_a = 32'h4C; bus.taken_a = 1'b1;
        bus.valid_b = 1'b1; bus.pc_b = 32'h50; bus.taken_b = 1'b1;
        #1;
        chk("c3_rdy_a", 64'(bus.ready_a),   64'd1);
        chk("c3_rdy_b", 64'(bus.ready_b),   64'd0);
        chk("c3_wr_en", 64'(bus.upd_wr_en), 64'd1);
        chk("c3_pc",    64'(bus.upd_pc),    64'h40);
        tick();
        idle_inputs();
        chk("c3_occ",   64'(bus.occupancy), 64'd3);
        chk("c3_pc1",   64'(bus.upd_pc),    64'h44);
        tick();
        chk("c3_pc2",   64'(bus.upd_pc),    64'h48);
        tick();
        chk("c3_pc3",   64'(bus.upd_pc),    64'h4C);
        tick();
        chk("c3_occ_end", 64'(bus.occupancy), 64'd0);

        // Flush with a concurrent push
        bus.hold = 1'b1;
        push_a(32'h60, 1'b1);
        push_a(32'h64, 1'b1);
        push_a(32'h68, 1'b1);
        bus.hold  = 1'b0;
        bus.flush = 1'b1;
        bus.valid_a = 1'b1; bus.pc_a = 32'h6C; bus.taken_a = 1'b1;
        #1;
        chk("fl_wr_en", 64'(bus.upd_wr_en), 64'd0);
        chk("fl_rdy_a", 64'(bus.ready_a),   64'd0);
        chk("fl_rdy_b", 64'(bus.ready_b),   64'd0);
        tick();
        idle_inputs();
        chk("fl_occ",   64'(bus.occupancy), 64'd0);
        chk("fl_wr2",   64'(bus.upd_wr_en), 64'd0);

        // Wrap: pointers restart at 0 after the flush
        bus.hold = 1'b1;
        push_a(32'h70, 1'b0);
        push_a(32'h74, 1'b0);
        push_a(32'h78, 1'b0);
        bus.hold = 1'b0;
        #1;
        chk("wr_pc0", 64'(bus.upd_pc), 64'h70);
        tick();
        chk("wr_pc1", 64'(bus.upd_pc), 64'h74);
        tick();
        chk("wr_pc2", 64'(bus.upd_pc), 64'h78);
        tick();
        chk("wr_empty", 64'(bus.occupancy), 64'd0);
        bus.valid_a = 1'b1; bus.pc_a = 32'h300; bus.taken_a = 1'b1;
        bus.valid_b = 1'b1; bus.pc_b = 32'h304; bus.taken_b = 1'b0;
        tick();
        idle_inputs();
        chk("wrap_occ",  64'(bus.occupancy), 64'd2);
        chk("wrap_pc0",  64'(bus.upd_pc),    64'h300);
        chk("wrap_tk0",  64'(bus.upd_taken), 64'd1);
        tick();
        chk("wrap_pc1",  64'(bus.upd_pc),    64'h304);
        chk("wrap_tk1",  64'(bus.upd_taken), 64'd0);
        chk("wrap_occ1", 64'(bus.occupancy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_occ", 64'(bus.occupancy), 64'd0);
        chk("mid_rst_wr",  64'(bus.upd_wr_en), 64'd0);

        // After reset, slot 0 is the head again
        push_a(32'h500, 1'b1);
        chk("post_rst_pc", 64'(bus.upd_pc),    64'h500);
        chk("post_rst_wr", 64'(bus.upd_wr_en), 64'd1);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
